// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: one FSM drives a shared adder, an internal register file and one unified memory port.
// Latency 3..5 cycles per instruction plus memory wait cycles; request outputs hold steady until mem_ready.
module mips_multicycle_core #(
    parameter int          REG_COUNT = 32,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              clr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc_out,
    output logic              retire,
    output logic              halted,
    output logic              F_zero,
    output logic              F_overflow
);
    localparam int RIDX_W = $clog2(REG_COUNT);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_q, alu_d, mdr_q, mdr_d;
    logic        zero_q, zero_d, ovf_q, ovf_d;
    logic [31:0] rf_q [REG_COUNT];

    logic              rf_we;
    logic [RIDX_W-1:0] rf_waddr;
    logic [31:0]       rf_wdata;

    logic [5:0]        opcode, funct;
    logic [RIDX_W-1:0] rs_idx, rt_idx, rd_idx;
    logic [31:0]       sext_imm, rs_val, rt_val;
    logic              legal;

    logic [31:0] add_a, add_b, add_b_eff, add_sum;
    logic        add_sub, add_ovf;
    logic [31:0] alu_res;
    logic        alu_ovf;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_idx   = ir_q[21 +: RIDX_W];
    assign rt_idx   = ir_q[16 +: RIDX_W];
    assign rd_idx   = ir_q[11 +: RIDX_W];
    assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
    assign rs_val   = rf_q[rs_idx];
    assign rt_val   = rf_q[rt_idx];

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                              (funct == FN_OR)  || (funct == FN_SLT);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Single adder shared by PC increment, branch target and execute; subtraction as a + ~b + 1.
    always_comb begin
        add_a   = pc_q;
        add_b   = 32'd4;
        add_sub = 1'b0;
        case (state_q)
            S_DECODE: add_b = {sext_imm[29:0], 2'b00};
            S_EXEC: begin
                add_a = a_q;
                if (opcode == OP_RTYPE) begin
                    add_b   = b_q;
                    add_sub = (funct == FN_SUB);
                end else begin
                    add_b = sext_imm;
                end
            end
            default: ;
        endcase
    end

    assign add_b_eff = add_sub ? ~add_b : add_b;
    assign add_sum   = add_a + add_b_eff + {31'd0, add_sub};
    assign add_ovf   = (add_a[31] == add_b_eff[31]) && (add_sum[31] != add_a[31]);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q[ADDR_W+1:2];
        mem_wdata = '0;
        retire    = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = rt_idx;
        rf_wdata  = alu_q;
        alu_res   = add_sum;
        alu_ovf   = add_ovf;
        case (state_q)
            S_FETCH: begin
                // Request is masked while clr is held so an abandoned access is visible at once.
                mem_req = !clr;
                if (mem_ready && !clr) begin
                    ir_d    = mem_rdata;
                    pc_d    = add_sum;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rs_val;
                b_d     = rt_val;
                alu_d   = add_sum;
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_AND: begin alu_res = a_q & b_q; alu_ovf = 1'b0; end
                            FN_OR:  begin alu_res = a_q | b_q; alu_ovf = 1'b0; end
                            FN_SLT: begin
                                alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
                                alu_ovf = 1'b0;
                            end
                            default: ;
                        endcase
                        alu_d   = alu_res;
                        zero_d  = (alu_res == 32'd0);
                        ovf_d   = alu_ovf;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alu_d   = add_sum;
                        zero_d  = (add_sum == 32'd0);
                        ovf_d   = add_ovf;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = add_sum;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) pc_d = alu_q;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = alu_q[ADDR_W+1:2];
                if (opcode == OP_SW) begin
                    mem_we    = 1'b1;
                    mem_wdata = b_q;
                end
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                if (opcode == OP_RTYPE) begin
                    rf_waddr = rd_idx;
                end else if (opcode == OP_LW) begin
                    rf_wdata = mdr_q;
                end
                rf_we   = (rf_waddr != '0);
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    // R0 is never written, so it reads as zero without a dedicated read mux.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign pc_out     = pc_q;
    assign halted     = (state_q == S_HALT);
    assign F_zero     = zero_q;
    assign F_overflow = ovf_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench: small programs run from a behavioural memory with programmable wait states.
module tb_mips_multicycle_core;
    localparam logic [31:0] RST_PC = 32'h0000_0020;
    localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;

    logic        clk = 1'b0;
    logic        clr;
    logic        mem_req, mem_we, mem_ready;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, pc_out;
    logic        retire, halted, F_zero, F_overflow;

    always #5 clk = ~clk;

    mips_multicycle_core #(.REG_COUNT(32), .ADDR_W(8), .RESET_PC(RST_PC)) dut (
        .clk(clk), .clr(clr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_out(pc_out), .retire(retire), .halted(halted), .F_zero(F_zero), .F_overflow(F_overflow)
    );

    logic [31:0] mem [256];
    int          wait_rd = 0, wait_wr = 0, wcnt = 0;
    logic        ld_clr = 1'b0, ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    int          wr_addr_q[$], wr_data_q[$];

    assign mem_ready = mem_req && (wcnt >= (mem_we ? wait_wr : wait_rd));
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (ld_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
        else if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_req && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
        if (clr || !mem_req || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (clr) begin
            wr_addr_q.delete();
            wr_data_q.delete();
        end else if (mem_req && mem_ready && mem_we) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(int'(mem_wdata));
        end
    end

    // Observation side: retire times, flags at retire, read addresses, request stability.
    int          cyc = 0, req_cycles = 0, we_cycles = 0, unstable = 0;
    int          ret_q[$], zf_q[$], of_q[$], rd_addr_q[$];
    logic        prev_wait = 1'b0, prev_we = 1'b0;
    logic [7:0]  prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (clr) begin
            ret_q.delete(); zf_q.delete(); of_q.delete(); rd_addr_q.delete();
            req_cycles = 0; we_cycles = 0; unstable = 0; prev_wait = 1'b0;
        end else begin
            if (retire) begin
                ret_q.push_back(cyc);
                zf_q.push_back(int'(F_zero));
                of_q.push_back(int'(F_overflow));
            end
            if (mem_req) req_cycles = req_cycles + 1;
            if (mem_req && mem_we) we_cycles = we_cycles + 1;
            if (mem_req && mem_ready && !mem_we) rd_addr_q.push_back(int'(mem_addr));
            if (prev_wait && (!mem_req || mem_addr !== prev_addr || mem_we !== prev_we ||
                              (mem_we && mem_wdata !== prev_wdata)))
                unstable = unstable + 1;
            prev_wait  = mem_req && !mem_ready;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
        end
    end

    int n_total = 0, n_bad = 0;
    int snap_req, snap_ret;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int gap(input int k);
        if (k < 1 || k >= ret_q.size()) return -1;
        return ret_q[k] - ret_q[k-1];
    endfunction
    function automatic int zf_at(input int k);
        return (k >= 0 && k < zf_q.size()) ? zf_q[k] : -1;
    endfunction
    function automatic int of_at(input int k);
        return (k >= 0 && k < of_q.size()) ? of_q[k] : -1;
    endfunction
    function automatic int rd_at(input int k);
        return (k >= 0 && k < rd_addr_q.size()) ? rd_addr_q[k] : -1;
    endfunction
    function automatic int wa_at(input int k);
        return (k >= 0 && k < wr_addr_q.size()) ? wr_addr_q[k] : -1;
    endfunction
    function automatic int wd_at(input int k);
        return (k >= 0 && k < wr_data_q.size()) ? wr_data_q[k] : -1;
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] tgt);
        return {OP_J, tgt[27:2]};
    endfunction

    task automatic start_prog();
        clr = 1'b1;
        @(negedge clk) ld_clr = 1'b1;
        @(negedge clk) ld_clr = 1'b0;
    endtask

    task automatic put(input int a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a[7:0]; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_prog(input int budget);
        @(negedge clk) clr = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        #1;
    endtask

    initial begin
        clr = 1'b1;
        start_prog();
        @(negedge clk);
        check("rst mem_req", {31'd0, mem_req}, 32'd0);
        check("rst pc_out", pc_out, RST_PC);
        check("rst halted", {31'd0, halted}, 32'd0);
        check("rst retire", {31'd0, retire}, 32'd0);
        check("rst F_zero", {31'd0, F_zero}, 32'd0);
        check("rst F_overflow", {31'd0, F_overflow}, 32'd0);
        wait_rd = 1000;
        @(negedge clk) clr = 1'b0;
        #1;
        check("first req", {31'd0, mem_req}, 32'd1);
        check("first addr", {24'd0, mem_addr}, 32'd8);
        check("first we", {31'd0, mem_we}, 32'd0);
        repeat (2) @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr drops req", {31'd0, mem_req}, 32'd0);
        check("clr pc", pc_out, RST_PC);
        wait_rd = 0;

        // ALU program
        start_prog();
        put(8,  enc_i(OP_ADDI, 5'd0, 5'd1, 16'd7));
        put(9,  enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFF9));
        put(10, enc_r(5'd1, 5'd2, 5'd3, FN_ADD));
        put(11, enc_r(5'd2, 5'd1, 5'd4, FN_SLT));
        put(12, enc_i(OP_SW, 5'd0, 5'd3, 16'h0080));
        put(13, enc_i(OP_SW, 5'd0, 5'd4, 16'h0084));
        put(14, enc_i(OP_SW, 5'd0, 5'd2, 16'h0088));
        put(15, {OP_HALT, 26'd0});
        put(32, 32'hDEADBEEF);
        run_prog(200);
        check("alu halted", {31'd0, halted}, 32'd1);
        check("alu retires", ret_q.size(), 32'd7);
        check("add r3", mem[32], 32'd0);
        check("slt r4", mem[33], 32'd1);
        check("addi neg r2", mem[34], 32'hFFFF_FFF9);
        check("addi cycles", gap(1), 32'd4);
        check("add cycles", gap(2), 32'd4);
        check("slt cycles", gap(3), 32'd4);
        check("sw cycles", gap(4), 32'd4);
        check("add F_zero", zf_at(2), 32'd1);
        check("slt F_zero", zf_at(3), 32'd0);
        check("slt F_overflow", of_at(3), 32'd0);

        // Overflow program
        start_prog();
        put(8,  enc_i(OP_ADDI, 5'd0, 5'd6, 16'd1));
        put(9,  enc_i(OP_LW, 5'd0, 5'd1, 16'h0080));
        put(10, enc_r(5'd1, 5'd1, 5'd2, FN_ADD));
        put(11, enc_r(5'd1, 5'd1, 5'd3, FN_SUB));
        put(12, enc_i(OP_SW, 5'd0, 5'd2, 16'h0084));
        put(13, enc_i(OP_SW, 5'd0, 5'd3, 16'h0088));
        put(14, {OP_HALT, 26'd0});
        put(32, 32'h7FFF_FFFF);
        put(34, 32'hDEADBEEF);
        run_prog(200);
        check("ovf halted", {31'd0, halted}, 32'd1);
        check("lw cycles", gap(1), 32'd5);
        check("add ovf result", mem[33], 32'hFFFF_FFFE);
        check("add F_overflow", of_at(2), 32'd1);
        check("add F_zero", zf_at(2), 32'd0);
        check("sub result", mem[34], 32'd0);
        check("sub F_overflow", of_at(3), 32'd0);
        check("sub F_zero", zf_at(3), 32'd1);

        // Memory with write wait states
        wait_wr = 3;
        start_prog();
        put(8,  enc_i(OP_ADDI, 5'd0, 5'd1, 16'h1234));
        put(9,  enc_i(OP_SW, 5'd0, 5'd1, 16'd8));
        put(10, enc_i(OP_LW, 5'd0, 5'd5, 16'd8));
        put(11, enc_i(OP_SW, 5'd0, 5'd5, 16'h0080));
        put(12, {OP_HALT, 26'd0});
        run_prog(200);
        check("mem halted", {31'd0, halted}, 32'd1);
        check("write count", wr_addr_q.size(), 32'd2);
        check("sw addr", wa_at(0), 32'd2);
        check("sw data", wd_at(0), 32'h1234);
        check("sw wait cycles", gap(1), 32'd7);
        check("lw after sw cycles", gap(2), 32'd5);
        check("lw r5 stored", mem[32], 32'h1234);
        check("we cycles", we_cycles, 32'd8);
        check("req stable", unstable, 32'd0);
        wait_wr = 0;

        // Control flow
        start_prog();
        put(8,  enc_j(32'h0000_0040));
        put(9,  enc_i(OP_ADDI, 5'd0, 5'd3, 16'd1));
        put(16, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5));
        put(17, enc_i(OP_ADDI, 5'd0, 5'd2, 16'd5));
        put(18, enc_i(OP_BEQ, 5'd1, 5'd0, 16'd5));
        put(19, enc_i(OP_BEQ, 5'd1, 5'd2, 16'd1));
        put(20, enc_i(OP_ADDI, 5'd0, 5'd3, 16'd99));
        put(21, enc_i(OP_ADDI, 5'd0, 5'd0, 16'd77));
        put(22, enc_i(OP_SW, 5'd0, 5'd0, 16'h0080));
        put(23, enc_i(OP_SW, 5'd0, 5'd3, 16'h0084));
        put(24, enc_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF));
        put(32, 32'hDEADBEEF);
        put(33, 32'hDEADBEEF);
        run_prog(90);
        check("j fetch addr", rd_at(1), 32'h10);
        check("addi after j cycles", gap(1), 32'd4);
        check("beq not taken cycles", gap(3), 32'd3);
        check("beq taken cycles", gap(4), 32'd3);
        check("beq taken target", rd_at(5), 32'd21);
        check("r0 stays 0", mem[32], 32'd0);
        check("skipped addi", mem[33], 32'd0);
        check("loop fetch addr", rd_at(rd_addr_q.size() - 1), 32'd24);
        check("loop cycles", gap(ret_q.size() - 1), 32'd3);
        check("loop not halted", {31'd0, halted}, 32'd0);

        // Halt opcode, then recovery via clr
        start_prog();
        put(8, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1));
        put(9, {OP_HALT, 26'd0});
        run_prog(100);
        check("halt halted", {31'd0, halted}, 32'd1);
        check("halt pc", pc_out, 32'h28);
        snap_req = req_cycles;
        snap_ret = ret_q.size();
        repeat (20) @(negedge clk);
        #1;
        check("halt no req", req_cycles - snap_req, 32'd0);
        check("halt no retire", ret_q.size() - snap_ret, 32'd0);
        check("halt pc frozen", pc_out, 32'h28);
        clr = 1'b1;
        #1;
        check("clr leaves halt", {31'd0, halted}, 32'd0);
        @(negedge clk) clr = 1'b0;
        #1;
        check("recover req", {31'd0, mem_req}, 32'd1);
        check("recover addr", {24'd0, mem_addr}, 32'd8);

        // Unsupported funct
        start_prog();
        put(8, enc_r(5'd1, 5'd2, 5'd3, 6'h00));
        run_prog(100);
        check("funct0 halted", {31'd0, halted}, 32'd1);
        check("funct0 retires", ret_q.size(), 32'd0);

        // Unsupported opcode
        start_prog();
        put(8, enc_i(6'h0D, 5'd0, 5'd1, 16'd3));
        run_prog(100);
        check("illegal op halted", {31'd0, halted}, 32'd1);
        check("illegal op retires", ret_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
